// File: rtl/symscan_pkg.sv
// Shared types and width helpers for the symmetry scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, mode encodings, CW/PW width functions.
package symscan_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } symscan_state_t;

   localparam logic MODE_MIRROR = 1'b0;   // bit k must equal bit WIDTH-1-k
   localparam logic MODE_ANTI   = 1'b1;   // bit k must equal ~bit WIDTH-1-k

   // Mismatch count width: must hold 0..WIDTH/2 inclusive.
   function automatic int symscan_cw(input int width);
      return $clog2(width / 2 + 1);
   endfunction

   // Pair index width; at least one bit so a single-pair word still has a port.
   function automatic int symscan_pw(input int width);
      return (width / 2 > 1) ? $clog2(width / 2) : 1;
   endfunction

endpackage

// File: rtl/symscan_lane_cmp.sv
// Compares LANES mirrored bit pairs; returns mismatch popcount and lowest mismatching lane.
// Latency: combinational, zero cycles.
// Backpressure: none (pure function of its inputs).
// Ports: lo_bits/hi_bits = the two bits of each pair, mode = mirror/anti-mirror,
//        mm_cnt = mismatches, mm_first = lowest mismatching lane, mm_vld = any mismatch.
module symscan_lane_cmp
   import symscan_pkg::*;
#(
   parameter  int LANES = 2,
   localparam int NW    = $clog2(LANES + 1),
   localparam int IW    = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic [LANES-1:0] lo_bits,
   input  logic [LANES-1:0] hi_bits,
   input  logic             mode,
   output logic [NW-1:0]    mm_cnt,
   output logic [IW-1:0]    mm_first,
   output logic             mm_vld
);

   logic [LANES-1:0] mm_vec;

   always_comb begin
      mm_cnt   = '0;
      mm_first = '0;
      mm_vld   = 1'b0;
      mm_vec   = (mode == MODE_ANTI) ? ~(lo_bits ^ hi_bits) : (lo_bits ^ hi_bits);
      // Walk from the top lane down so the last hit written is the lowest index.
      for (int i = LANES - 1; i >= 0; i--) begin
         if (mm_vec[i]) begin
            mm_cnt   = mm_cnt + NW'(1);
            mm_first = IW'(i);
            mm_vld   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/symmetry_scanner.sv
// Multi-cycle mirrored-pair symmetry checker with saturating result statistics.
// Latency: result valid NPAIR/LANES cycles after the accepting edge; one word in flight.
// Backpressure: result held in DONE until out_ready; in_ready low from accept to handshake.
// Ports: in_valid/in_ready/in_data/in_mode = word input, out_* = per-word result,
//        stat_clr/stat_words/stat_syms = consumed-result counters.
module symmetry_scanner
   import symscan_pkg::*;
#(
   parameter  int WIDTH  = 16,
   parameter  int LANES  = 2,
   parameter  int STAT_W = 16,
   localparam int NPAIR  = WIDTH / 2,
   localparam int CW     = symscan_cw(WIDTH),
   localparam int PW     = symscan_pw(WIDTH),
   localparam int NSTEP  = NPAIR / LANES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_data,
   input  logic              in_mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_sym,
   output logic [CW-1:0]     out_mismatch,
   output logic [PW-1:0]     out_first,
   input  logic              stat_clr,
   output logic [STAT_W-1:0] stat_words,
   output logic [STAT_W-1:0] stat_syms
);

   localparam int SW = (NSTEP > 1) ? $clog2(NSTEP) : 1;
   localparam int NW = $clog2(LANES + 1);
   localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

   symscan_state_t    state_q, state_d;
   logic [WIDTH-1:0]  word_q, word_d;
   logic              mode_q, mode_d;
   logic [SW-1:0]     step_q, step_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [PW-1:0]     first_q, first_d;
   logic              first_vld_q, first_vld_d;
   logic [STAT_W-1:0] stat_words_q, stat_words_d;
   logic [STAT_W-1:0] stat_syms_q, stat_syms_d;

   logic [WIDTH-1:0]  word_rev;
   logic [LANES-1:0]  lo_bits, hi_bits;
   logic [NW-1:0]     lane_cnt;
   logic [IW-1:0]     lane_first;
   logic              lane_vld;
   logic              res_hs;
   int                shamt;

   // Reversing the word once lets both halves of a step be picked by the same shift.
   always_comb begin
      word_rev = '0;
      for (int k = 0; k < WIDTH; k++) begin
         word_rev[k] = word_q[WIDTH-1-k];
      end
      shamt   = int'(step_q) * LANES;
      lo_bits = LANES'(word_q >> shamt);
      hi_bits = LANES'(word_rev >> shamt);
   end

   symscan_lane_cmp #(.LANES(LANES)) u_lane_cmp (
      .lo_bits  (lo_bits),
      .hi_bits  (hi_bits),
      .mode     (mode_q),
      .mm_cnt   (lane_cnt),
      .mm_first (lane_first),
      .mm_vld   (lane_vld)
   );

   always_comb begin
      state_d      = state_q;
      word_d       = word_q;
      mode_d       = mode_q;
      step_d       = step_q;
      cnt_d        = cnt_q;
      first_d      = first_q;
      first_vld_d  = first_vld_q;
      stat_words_d = stat_words_q;
      stat_syms_d  = stat_syms_q;
      res_hs       = (state_q == DONE) && out_ready;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               word_d      = in_data;
               mode_d      = in_mode;
               step_d      = '0;
               cnt_d       = '0;
               first_d     = '0;
               first_vld_d = 1'b0;
               state_d     = SCAN;
            end
         end
         SCAN: begin
            cnt_d = cnt_q + CW'(lane_cnt);
            if (!first_vld_q && lane_vld) begin
               first_d     = PW'(shamt + int'(lane_first));
               first_vld_d = 1'b1;
            end
            if (step_q == SW'(NSTEP - 1)) begin
               state_d = DONE;
            end else begin
               step_d = step_q + SW'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Clear takes priority: a handshake in the same cycle is not counted.
      if (stat_clr) begin
         stat_words_d = '0;
         stat_syms_d  = '0;
      end else if (res_hs) begin
         if (stat_words_q != '1) begin
            stat_words_d = stat_words_q + STAT_W'(1);
         end
         if ((cnt_q == '0) && (stat_syms_q != '1)) begin
            stat_syms_d = stat_syms_q + STAT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         word_q       <= '0;
         mode_q       <= MODE_MIRROR;
         step_q       <= '0;
         cnt_q        <= '0;
         first_q      <= '0;
         first_vld_q  <= 1'b0;
         stat_words_q <= '0;
         stat_syms_q  <= '0;
      end else begin
         state_q      <= state_d;
         word_q       <= word_d;
         mode_q       <= mode_d;
         step_q       <= step_d;
         cnt_q        <= cnt_d;
         first_q      <= first_d;
         first_vld_q  <= first_vld_d;
         stat_words_q <= stat_words_d;
         stat_syms_q  <= stat_syms_d;
      end
   end

   // Result fields read as zero outside DONE so partial SCAN sums never leak out.
   assign in_ready     = (state_q == IDLE) && !rst;
   assign out_valid    = (state_q == DONE);
   assign out_sym      = out_valid && (cnt_q == '0);
   assign out_mismatch = out_valid ? cnt_q : '0;
   assign out_first    = out_valid ? first_q : '0;
   assign stat_words   = stat_words_q;
   assign stat_syms    = stat_syms_q;

endmodule

// File: tb/tb_symmetry_scanner.sv
// Bench for symmetry_scanner: an 8-bit/2-lane instance and a 16-bit/8-lane (single-step) instance,
// both with 2-bit statistics counters, checked against a reference model through a scoreboard.
module tb_symmetry_scanner;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Instance A: WIDTH=8, LANES=2 (two scan steps).
   logic       a_in_valid = 1'b0, a_in_ready, a_in_mode = 1'b0;
   logic [7:0] a_in_data = '0;
   logic       a_out_valid, a_out_ready = 1'b1, a_out_sym, a_stat_clr = 1'b0;
   logic [2:0] a_out_mismatch;
   logic [1:0] a_out_first, a_stat_words, a_stat_syms;

   // Instance B: WIDTH=16, LANES=8 (single scan step).
   logic        b_in_valid = 1'b0, b_in_ready, b_in_mode = 1'b0;
   logic [15:0] b_in_data = '0;
   logic        b_out_valid, b_out_ready = 1'b1, b_out_sym, b_stat_clr = 1'b0;
   logic [3:0]  b_out_mismatch;
   logic [2:0]  b_out_first;
   logic [1:0]  b_stat_words, b_stat_syms;

   symmetry_scanner #(.WIDTH(8), .LANES(2), .STAT_W(2)) u_dut_a (
      .clk(clk), .rst(rst),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mode(a_in_mode),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_sym(a_out_sym),
      .out_mismatch(a_out_mismatch), .out_first(a_out_first),
      .stat_clr(a_stat_clr), .stat_words(a_stat_words), .stat_syms(a_stat_syms)
   );

   symmetry_scanner #(.WIDTH(16), .LANES(8), .STAT_W(2)) u_dut_b (
      .clk(clk), .rst(rst),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mode(b_in_mode),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sym(b_out_sym),
      .out_mismatch(b_out_mismatch), .out_first(b_out_first),
      .stat_clr(b_stat_clr), .stat_words(b_stat_words), .stat_syms(b_stat_syms)
   );

   typedef struct {
      logic       sym;
      logic [7:0] mm;
      logic [7:0] first;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb, ebp;

   int n_cmp = 0;
   int n_err = 0;

   // {mode, data} tables
   logic [16:0] vec_a [4] = '{17'h00081, 17'h0000F, 17'h00010, 17'h1000F};
   logic [16:0] vec_b [4] = '{17'h08001, 17'h000FF, 17'h00100, 17'h100FF};
   logic [15:0] sym_a [5] = '{16'h0081, 16'h0018, 16'h0000, 16'h00FF, 16'h0066};
   logic [15:0] sym_b [5] = '{16'h8001, 16'h0180, 16'h0000, 16'hFFFF, 16'hF00F};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Independent pair-by-pair reference.
   function automatic exp_t model(input logic [15:0] d, input int w, input logic m);
      exp_t e;
      int   c;
      int   f;
      c = 0;
      f = -1;
      for (int k = 0; k < w / 2; k++) begin
         if (m ? (d[k] == d[w-1-k]) : (d[k] != d[w-1-k])) begin
            c++;
            if (f < 0) f = k;
         end
      end
      e.sym   = (c == 0);
      e.mm    = 8'(c);
      e.first = (f < 0) ? 8'd0 : 8'(f);
      return e;
   endfunction

   function automatic logic [31:0] ov(input bit b); return b ? 32'(b_out_valid) : 32'(a_out_valid); endfunction
   function automatic logic [31:0] ir(input bit b); return b ? 32'(b_in_ready) : 32'(a_in_ready); endfunction
   function automatic logic [31:0] os(input bit b); return b ? 32'(b_out_sym) : 32'(a_out_sym); endfunction
   function automatic logic [31:0] om(input bit b); return b ? 32'(b_out_mismatch) : 32'(a_out_mismatch); endfunction
   function automatic logic [31:0] of(input bit b); return b ? 32'(b_out_first) : 32'(a_out_first); endfunction
   function automatic logic [31:0] sw(input bit b); return b ? 32'(b_stat_words) : 32'(a_stat_words); endfunction
   function automatic logic [31:0] ss(input bit b); return b ? 32'(b_stat_syms) : 32'(a_stat_syms); endfunction

   task automatic set_ordy(input bit b, input logic v);
      if (b) b_out_ready = v; else a_out_ready = v;
   endtask

   task automatic set_clr(input bit b, input logic v);
      if (b) b_stat_clr = v; else a_stat_clr = v;
   endtask

   // Scoreboard side: compare every result handshake with the oldest expectation.
   always @(negedge clk) begin
      if (!rst && a_out_valid && a_out_ready) begin
         if (qa.size() == 0) begin
            check("a_unexpected_result", 32'(a_out_valid), 32'd0);
         end else begin
            ea = qa.pop_front();
            check("a_sym", 32'(a_out_sym), 32'(ea.sym));
            check("a_mismatch", 32'(a_out_mismatch), 32'(ea.mm));
            check("a_first", 32'(a_out_first), 32'(ea.first));
         end
      end
      if (!rst && b_out_valid && b_out_ready) begin
         if (qb.size() == 0) begin
            check("b_unexpected_result", 32'(b_out_valid), 32'd0);
         end else begin
            eb = qb.pop_front();
            check("b_sym", 32'(b_out_sym), 32'(eb.sym));
            check("b_mismatch", 32'(b_out_mismatch), 32'(eb.mm));
            check("b_first", 32'(b_out_first), 32'(eb.first));
         end
      end
   end

   // Called and returns at posedge+1. Input bus is scrambled after acceptance.
   task automatic send(input bit b, input logic [15:0] d, input logic m);
      bit acc;
      acc = 1'b0;
      if (b) begin b_in_valid = 1'b1; b_in_data = d; b_in_mode = m; end
      else   begin a_in_valid = 1'b1; a_in_data = d[7:0]; a_in_mode = m; end
      for (int i = 0; i < 40 && !acc; i++) begin
         @(negedge clk);
         acc = (ir(b) == 32'd1);
         @(posedge clk); #1;
      end
      a_in_valid = 1'b0;
      b_in_valid = 1'b0;
      a_in_data  = 8'($urandom);
      b_in_data  = 16'($urandom);
      a_in_mode  = 1'($urandom);
      b_in_mode  = 1'($urandom);
      if (!acc) check("accept_timeout", ir(b), 32'd1);
      else if (b) qb.push_back(model(d, 16, m));
      else qa.push_back(model(d, 8, m));
   endtask

   task automatic drain(input bit b);
      for (int i = 0; i < 100 && (b ? qb.size() : qa.size()) != 0; i++) begin
         @(posedge clk); #1;
      end
      check("drain_timeout", b ? 32'(qb.size()) : 32'(qa.size()), 32'd0);
   endtask

   // Returns at the negedge where out_valid is seen.
   task automatic wait_valid(input bit b);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         seen = (ov(b) == 32'd1);
      end
      if (!seen) check("valid_timeout", ov(b), 32'd1);
   endtask

   task automatic run_suite(input bit b, input int w, input int nstep);
      logic [16:0] v;
      logic [15:0] d;
      set_ordy(b, 1'b1);

      // Directed and random words through the scoreboard.
      for (int i = 0; i < 4; i++) begin
         v = b ? vec_b[i] : vec_a[i];
         send(b, v[15:0], v[16]);
      end
      for (int i = 0; i < 8; i++) begin
         d = (w == 8) ? 16'($urandom_range(0, 255)) : 16'($urandom);
         send(b, d, 1'($urandom));
      end
      drain(b);

      // Latency and in_ready with out_ready held high.
      send(b, b ? 16'h0180 : 16'h0018, 1'b0);
      for (int i = 0; i <= nstep + 1; i++) begin
         @(negedge clk);
         check("lat_valid", ov(b), 32'(i == nstep));
         check("lat_ready", ir(b), 32'(i == nstep + 1));
      end
      @(posedge clk); #1;

      // Clear statistics, then hold a result under backpressure.
      set_clr(b, 1'b1);
      @(posedge clk); #1;
      set_clr(b, 1'b0);
      @(negedge clk);
      check("clr_words", sw(b), 32'd0);
      check("clr_syms", ss(b), 32'd0);
      @(posedge clk); #1;
      set_ordy(b, 1'b0);
      send(b, 16'h0001, 1'b0);
      ebp = model(16'h0001, w, 1'b0);
      wait_valid(b);
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", ov(b), 32'd1);
         check("bp_ready", ir(b), 32'd0);
         check("bp_sym", os(b), 32'(ebp.sym));
         check("bp_mismatch", om(b), 32'(ebp.mm));
         check("bp_first", of(b), 32'(ebp.first));
         check("bp_words", sw(b), 32'd0);
         @(posedge clk); #1;
         @(negedge clk);
      end
      @(posedge clk); #1;
      set_ordy(b, 1'b1);
      @(negedge clk);
      check("bp_words_pending", sw(b), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_words_after", sw(b), 32'd1);
      check("bp_syms_after", ss(b), 32'd0);
      @(posedge clk); #1;

      // Saturation at 2^STAT_W-1 = 3.
      for (int i = 0; i < 5; i++) send(b, b ? sym_b[i] : sym_a[i], 1'b0);
      drain(b);
      @(negedge clk);
      check("sat_words", sw(b), 32'd3);
      check("sat_syms", ss(b), 32'd3);
      @(posedge clk); #1;

      // Clear coinciding with a handshake: clear wins.
      set_ordy(b, 1'b0);
      send(b, b ? sym_b[0] : sym_a[0], 1'b0);
      wait_valid(b);
      @(posedge clk); #1;
      set_ordy(b, 1'b1);
      set_clr(b, 1'b1);
      @(posedge clk); #1;
      set_clr(b, 1'b0);
      @(negedge clk);
      check("clrhs_words", sw(b), 32'd0);
      check("clrhs_syms", ss(b), 32'd0);
      check("clrhs_valid", ov(b), 32'd0);
      @(posedge clk); #1;

      // Reset mid-scan: one counted word first so the clear is observable.
      send(b, b ? sym_b[1] : sym_a[1], 1'b0);
      drain(b);
      send(b, 16'h00F0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      check("rst_ready_low", ir(b), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      if (b) qb.delete(); else qa.delete();
      @(negedge clk);
      check("rst_valid", ov(b), 32'd0);
      check("rst_sym", os(b), 32'd0);
      check("rst_mismatch", om(b), 32'd0);
      check("rst_first", of(b), 32'd0);
      check("rst_words", sw(b), 32'd0);
      check("rst_syms", ss(b), 32'd0);
      check("rst_ready", ir(b), 32'd1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rst_no_result", ov(b), 32'd0);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_a_ready", ir(0), 32'd0);
      check("rst_b_ready", ir(1), 32'd0);
      check("rst_a_valid", ov(0), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      for (int b = 0; b < 2; b++) begin
         check("init_ready", ir(b[0]), 32'd1);
         check("init_valid", ov(b[0]), 32'd0);
         check("init_sym", os(b[0]), 32'd0);
         check("init_mismatch", om(b[0]), 32'd0);
         check("init_first", of(b[0]), 32'd0);
         check("init_words", sw(b[0]), 32'd0);
         check("init_syms", ss(b[0]), 32'd0);
      end
      @(posedge clk); #1;

      run_suite(1'b0, 8, 2);
      run_suite(1'b1, 16, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/symmetry_scanner.md
# symmetry_scanner

Parametrised, handshaked successor to the combinational 8-bit symmetry detector. It accepts a WIDTH-bit word and scans its mirrored bit pairs over several cycles, LANES pairs per cycle. Per word it reports a symmetry flag, the mismatch count and the index of the first mismatching pair. It also keeps saturating statistics counters. It sits between the `ui_in` capture logic and the output mux of the Tiny Tapeout top level.

## Interface
Parameters:
- `WIDTH`, 16: word width; must be even and ≥ 2.
- `LANES`, 2: pairs compared per cycle; must divide WIDTH/2.
- `STAT_W`, 16: width of each statistics counter.
- Derived constants:
  - `NPAIR` = WIDTH/2.
  - `CW` = $clog2(NPAIR+1).
  - `PW` = max(1, $clog2(NPAIR)).
  - `NSTEP` = NPAIR/LANES.

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  word offered.
- `in_ready`  out  1  block can accept a word.
- `in_data`  in  WIDTH  word to check.
- `in_mode`  in  1  0 = mirror (bit k == bit WIDTH-1-k); 1 = anti-mirror (bit k == ~bit WIDTH-1-k).
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `out_sym`  out  1  1 when all pairs match.
- `out_mismatch`  out  CW  number of mismatching pairs, 0..NPAIR.
- `out_first`  out  PW  lowest mismatching pair index k; 0 when out_sym=1.
- `stat_clr`  in  1  synchronous clear of both statistics counters.
- `stat_words`  out  STAT_W  results consumed; saturating.
- `stat_syms`  out  STAT_W  consumed results with out_sym=1; saturating.

## Operation
- Pair k is bit k together with bit WIDTH-1-k, for k = 0..NPAIR-1.
  - Mode 0: pair mismatches when the two bits differ.
  - Mode 1: pair mismatches when the two bits are equal.
- FSM states are IDLE, SCAN and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: register in_data and in_mode, clear the accumulators, set step=0, go to SCAN.
- SCAN:
  - Each cycle, compare pairs step·LANES .. step·LANES+LANES-1.
  - Add the number of mismatches in those pairs to the count.
  - If no mismatch has been recorded yet, record the lowest mismatching index in this step as the first index.
  - step increments each cycle. When step=NSTEP-1, go to DONE.
- DONE:
  - out_valid=1; all out_* outputs are held stable.
  - On out_ready: update the statistics and go to IDLE.
- in_ready is 0 in SCAN and DONE. A word is never accepted in the same cycle as a result handshake.
- Data is taken only from the registered copy; in_data may change after acceptance.
- out_sym = (count == 0).
- Accumulator width is CW; the count cannot overflow, since its maximum is NPAIR.
- Statistics:
  - On a result handshake, stat_words increments by 1, and stat_syms increments by 1 if out_sym=1.
  - Each counter holds at 2^STAT_W-1 once it saturates.
  - If stat_clr is high in the same cycle as a handshake, clear wins: both counters become 0 and that handshake is not counted.

## Timing
- Reset values (in rst cycles and the first cycle after):
  - State is IDLE.
  - out_valid, out_sym, out_mismatch, out_first, stat_words and stat_syms are all 0.
  - in_ready is 0 while rst is high and 1 from the first cycle after.
- Latency: word accepted at edge E0 → SCAN during edges E1..E_NSTEP → out_valid high after edge E_NSTEP.
  - Example: WIDTH=8, LANES=2 gives NSTEP=2, so out_valid is high 2 cycles after acceptance.
- Throughput: at best one word per NSTEP+2 cycles.
- out_valid may stay high indefinitely under backpressure; results are never dropped.
- rst mid-SCAN or mid-DONE: the word is abandoned, no result is produced, and statistics are cleared.
- LANES = NPAIR is legal: the scan completes in a single cycle.

## Structure
- Shared package `symscan_pkg` holds:
  - the state enum `symscan_state_t` (IDLE, SCAN, DONE);
  - the mode constants `MODE_MIRROR`=0 and `MODE_ANTI`=1;
  - a function computing CW/PW from WIDTH.
- One sub-module, `symscan_lane_cmp`: combinational; takes LANES bit pairs and the mode, and returns the popcount of mismatches plus the lowest mismatching lane index and a valid bit.
- The top level owns the FSM, accumulators and statistics counters.

## Test plan
- WIDTH=8, LANES=2, mode 0:
  - 0x81 → out_sym=1, mismatch=0, first=0.
  - 0x0F → sym=0, mismatch=4, first=0.
- Mode 0, 0x10 → sym=0, mismatch=1, first=3. Mode 1, 0x0F → sym=1, mismatch=0.
- Latency/handshake: accept 0x18 with out_ready held high → out_valid exactly 2 cycles after acceptance, in_ready low for 3 cycles, then high.
- Backpressure: out_ready low for 5 cycles → out_valid and all outputs stable, in_ready=0, stat_words unchanged until release, then +1.
- Statistics with STAT_W=2:
  - Send 5 symmetric words → stat_words=3 and stat_syms=3 (saturated).
  - stat_clr asserted in the same cycle as a handshake → both counters 0.
- rst asserted mid-SCAN → no out_valid, all outputs 0, in_ready=1 in the first cycle after rst. Run the same checks with WIDTH=16, LANES=8 (single-cycle scan).
